core_mem_arbiter: RTL and testbench

// - Parametrised N-channel memory arbiter. Shares the core's single memory port between IF, the new MEM stage and future masters (e.g. debug).
// - Grants one request at a time. Drives the external MEM_* interface and returns data/valid/error to the granted channel.
// - Sits in core_top between the pipeline stages and the memory interface.

---
 rtl/core_pkg.sv | 13 +
 rtl/core_rr_picker.sv | 32 +++
 rtl/core_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_core_mem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the core memory arbitration path.
package core_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/core_rr_picker.sv
// Combinational grant picker: fixed priority from index 0, or round robin
// starting at ptr. Yields a one-hot grant plus its index.
module core_rr_picker #(
  parameter int NUM_CH = 2,
  parameter int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  input  logic              rr_mode,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0]     gnt_idx,
  output logic              any
);

  always_comb begin : pick
    int c;
    c       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = rr_mode ? int'(ptr) + i : i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!any && req[c]) begin
        any     = 1'b1;
        gnt_idx = IW'(c);
      end
    end
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// N-channel arbiter for the single core memory port: IDLE grants, BUSY holds
// the strobe until memory completes (or times out), RESP pulses the requester.
module core_mem_arbiter
  import core_pkg::*;
#(
  parameter int BITSIZE        = 32,
  parameter int NUM_CH         = 2,
  parameter int ARB_MODE       = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                             clk,
  input  logic                             resetn_i,
  input  logic [NUM_CH-1:0]                req_read_i,
  input  logic [NUM_CH-1:0]                req_write_i,
  input  logic [NUM_CH-1:0][BITSIZE-1:0]   req_addr_i,
  input  logic [NUM_CH-1:0][BITSIZE-1:0]   req_wdata_i,
  input  logic [NUM_CH-1:0][BITSIZE/8-1:0] req_be_i,
  output logic [NUM_CH-1:0]                req_valid_o,
  output logic                             req_err_o,
  output logic [BITSIZE-1:0]               req_rdata_o,
  output logic [BITSIZE-1:0]               MEM_addr_o,
  output logic [BITSIZE-1:0]               MEM_data_o,
  output logic [BITSIZE/8-1:0]             MEM_be_o,
  output logic                             MEM_read_o,
  output logic                             MEM_write_o,
  input  logic [BITSIZE-1:0]               MEM_data_i,
  input  logic                             MEM_valid_i
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = BITSIZE / 8;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t          state_q, state_d;
  logic [NUM_CH-1:0]   req_any, gnt_oh, gnt_oh_q;
  logic [IW-1:0]       gnt_idx, ptr_q;
  logic                gnt_any, wr_q, err_q, abort;
  logic [BITSIZE-1:0]  addr_q, wdata_q, rdata_q;
  logic [BW-1:0]       be_q;
  logic [TW-1:0]       tcnt_q;

  assign req_any = req_read_i | req_write_i;

  core_rr_picker #(.NUM_CH(NUM_CH), .IW(IW)) u_pick (
    .req     (req_any),
    .ptr     (ptr_q),
    .rr_mode (ARB_MODE == ARB_RR),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Abort fires on the last allowed BUSY cycle; a same-cycle MEM_valid_i takes precedence.
  assign abort = (TIMEOUT_CYCLES > 0) && (int'(tcnt_q) == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) state_q <= ARB_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    MEM_read_o  = 1'b0;
    MEM_write_o = 1'b0;
    req_valid_o = '0;
    req_err_o   = 1'b0;
    case (state_q)
      ARB_IDLE: if (gnt_any) state_d = ARB_BUSY;
      ARB_BUSY: begin
        MEM_read_o  = !wr_q;
        MEM_write_o = wr_q;
        if (MEM_valid_i || abort) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        req_valid_o = gnt_oh_q;
        req_err_o   = err_q;
        state_d     = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      gnt_oh_q <= '0;
      ptr_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      tcnt_q   <= '0;
    end else if (state_q == ARB_IDLE && gnt_any) begin
      gnt_oh_q <= gnt_oh;
      ptr_q    <= (int'(gnt_idx) == NUM_CH - 1) ? IW'(0) : gnt_idx + IW'(1);
      wr_q     <= req_write_i[gnt_idx];
      addr_q   <= req_addr_i[gnt_idx];
      wdata_q  <= req_wdata_i[gnt_idx];
      be_q     <= req_be_i[gnt_idx];
      tcnt_q   <= '0;
    end else if (state_q == ARB_BUSY) begin
      if (MEM_valid_i) begin
        rdata_q <= wr_q ? '0 : MEM_data_i;
        err_q   <= 1'b0;
      end else if (abort) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        tcnt_q  <= TW'(TIMEOUT_CYCLES);
      end else begin
        tcnt_q  <= tcnt_q + TW'(1);
      end
    end
  end

  assign req_rdata_o = rdata_q;
  assign MEM_addr_o  = addr_q;
  assign MEM_data_o  = wdata_q;
  assign MEM_be_o    = be_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench: d0 is round robin with a 4-cycle timeout, d1 is fixed
// priority without timeout; both see the same request stimulus.
module tb_core_mem_arbiter;
  localparam int W = 32;
  localparam int N = 2;
  localparam int BW = W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  logic [N-1:0] rreq, wreq;
  logic [N-1:0][W-1:0] addr, wdata;
  logic [N-1:0][BW-1:0] be;
  logic [W-1:0] mdata;
  int lat;

  logic [N-1:0]  v0, v1;
  logic          e0, e1, mr0, mw0, mr1, mw1;
  logic          mv0 = 1'b0, mv1 = 1'b0;
  logic [W-1:0]  rd0, rd1, ma0, ma1, md0, md1;
  logic [BW-1:0] mb0, mb1;

  core_mem_arbiter #(.BITSIZE(W), .NUM_CH(N), .ARB_MODE(1), .TIMEOUT_CYCLES(4)) d0 (
    .clk(clk), .resetn_i(rst0), .req_read_i(rreq), .req_write_i(wreq),
    .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be),
    .req_valid_o(v0), .req_err_o(e0), .req_rdata_o(rd0),
    .MEM_addr_o(ma0), .MEM_data_o(md0), .MEM_be_o(mb0),
    .MEM_read_o(mr0), .MEM_write_o(mw0), .MEM_data_i(mdata), .MEM_valid_i(mv0));

  core_mem_arbiter #(.BITSIZE(W), .NUM_CH(N), .ARB_MODE(0), .TIMEOUT_CYCLES(0)) d1 (
    .clk(clk), .resetn_i(rst1), .req_read_i(rreq), .req_write_i(wreq),
    .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be),
    .req_valid_o(v1), .req_err_o(e1), .req_rdata_o(rd1),
    .MEM_addr_o(ma1), .MEM_data_o(md1), .MEM_be_o(mb1),
    .MEM_read_o(mr1), .MEM_write_o(mw1), .MEM_data_i(mdata), .MEM_valid_i(mv1));

  // Memory model: completes in the lat-th strobe cycle; lat=0 never completes.
  int c0 = 0, c1 = 0;
  always @(posedge clk) begin
    c0 <= (mr0 | mw0) ? c0 + 1 : 0;
    c1 <= (mr1 | mw1) ? c1 + 1 : 0;
  end
  always @(negedge clk) begin
    mv0 = (mr0 | mw0) && lat > 0 && c0 == lat - 1;
    mv1 = (mr1 | mw1) && lat > 0 && c1 == lat - 1;
  end

  typedef struct {
    logic [N-1:0] vld;
    logic [W-1:0] rdata;
    logic         err;
  } exp_t;

  exp_t q0[$];
  int   ctimes[$];
  int   npass = 0, ntot = 0, cyc = 0;
  int   d1c0 = 0, d1c1 = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic expect_c(input logic [N-1:0] vld, input logic [W-1:0] rdata, input logic err);
    exp_t e;
    e.vld = vld; e.rdata = rdata; e.err = err;
    q0.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (v0 != '0) begin
      ctimes.push_back(cyc);
      if (q0.size() == 0) chk("unexpected_valid", 64'(v0), 64'd0);
      else begin
        e = q0.pop_front();
        chk("valid_vec", 64'(v0), 64'(e.vld));
        chk("rdata", 64'(rd0), 64'(e.rdata));
        chk("err", 64'(e0), 64'(e.err));
      end
    end else if (e0 !== 1'b0) chk("err_without_valid", 64'(e0), 64'd0);
    if (v1[0]) d1c0++;
    if (v1[1]) d1c1++;
  end

  // Runs one d0 transaction; drops all requests in the response cycle.
  task automatic run_txn(output int rcyc, output int wcyc, output logic [W-1:0] fa,
                         output logic [W-1:0] fd, output logic [BW-1:0] fb, output logic fw);
    bit seen = 0, done = 0;
    rcyc = 0; wcyc = 0; fa = '0; fd = '0; fb = '0; fw = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (mr0) rcyc++;
      if (mw0) wcyc++;
      if ((mr0 | mw0) && !seen) begin
        seen = 1; fa = ma0; fd = md0; fb = mb0; fw = mw0;
      end
      if (v0 != '0) begin
        done = 1; rreq = '0; wreq = '0;
      end
    end
    if (!done) chk("txn_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); rst0 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rc, wc, n, b0, b1;
    logic [W-1:0] fa, fd;
    logic [BW-1:0] fb;
    logic fw;
    rst0 = 1'b0; rst1 = 1'b0; rreq = '0; wreq = '0;
    addr = '0; wdata = '0; be = '0; mdata = '0; lat = 1;
    repeat (2) @(negedge clk);
    chk("rst_read", 64'(mr0), 64'd0);
    chk("rst_write", 64'(mw0), 64'd0);
    chk("rst_valid", 64'(v0), 64'd0);
    chk("rst_err", 64'(e0), 64'd0);
    chk("rst_rdata", 64'(rd0), 64'd0);
    chk("rst_addr", 64'(ma0), 64'd0);
    rst0 = 1'b1; rst1 = 1'b1;
    @(negedge clk);

    // single read, memory answers in 3rd strobe cycle
    lat = 3; mdata = 32'hDEADBEEF;
    expect_c(2'b01, 32'hDEADBEEF, 1'b0);
    addr[0] = 32'h100; rreq = 2'b01;
    run_txn(rc, wc, fa, fd, fb, fw);
    chk("t1_read_cycles", 64'(rc), 64'd3);
    chk("t1_write_cycles", 64'(wc), 64'd0);
    chk("t1_addr", 64'(fa), 64'h100);

    // both channels request continuously, 1-cycle memory
    do_reset();
    lat = 1; mdata = 32'h12345678;
    b0 = d1c0; b1 = d1c1;
    ctimes.delete();
    expect_c(2'b01, 32'h12345678, 1'b0);
    expect_c(2'b10, 32'h12345678, 1'b0);
    expect_c(2'b01, 32'h12345678, 1'b0);
    expect_c(2'b10, 32'h12345678, 1'b0);
    addr[0] = 32'h200; addr[1] = 32'h300; rreq = 2'b11;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (v0 != '0) n++;
    end
    rreq = '0;
    chk("t2_completions", 64'(n), 64'd4);
    repeat (3) @(negedge clk);
    chk("t2_stamps", 64'(ctimes.size()), 64'd4);
    if (ctimes.size() >= 4) begin
      chk("t2_gap_0_1", 64'(ctimes[1] - ctimes[0]), 64'd3);
      chk("t2_period_ch0", 64'(ctimes[2] - ctimes[0]), 64'd6);
      chk("t2_period_ch1", 64'(ctimes[3] - ctimes[1]), 64'd6);
    end
    chk("t3_fixed_ch0", 64'(d1c0 - b0), 64'd4);
    chk("t3_fixed_ch1", 64'(d1c1 - b1), 64'd0);

    // write with read also high on ch1
    lat = 2; mdata = 32'hFFFFFFFF;
    expect_c(2'b10, 32'h0, 1'b0);
    addr[1] = 32'h20; wdata[1] = 32'hCAFE0000; be[1] = 4'b1100;
    rreq = 2'b10; wreq = 2'b10;
    run_txn(rc, wc, fa, fd, fb, fw);
    chk("t4_write_cycles", 64'(wc), 64'd2);
    chk("t4_read_cycles", 64'(rc), 64'd0);
    chk("t4_write_strobe", 64'(fw), 64'd1);
    chk("t4_addr", 64'(fa), 64'h20);
    chk("t4_wdata", 64'(fd), 64'hCAFE0000);
    chk("t4_be", 64'(fb), 64'b1100);

    // timeout: memory never answers
    lat = 0; mdata = 32'hBAD0BAD0;
    expect_c(2'b01, 32'h0, 1'b1);
    addr[0] = 32'h400; rreq = 2'b01;
    run_txn(rc, wc, fa, fd, fb, fw);
    chk("t5_strobe_cycles", 64'(rc), 64'd4);

    lat = 1; mdata = 32'h55AA55AA;
    expect_c(2'b01, 32'h55AA55AA, 1'b0);
    addr[0] = 32'h500; rreq = 2'b01;
    run_txn(rc, wc, fa, fd, fb, fw);
    chk("t5_recover_cycles", 64'(rc), 64'd1);
    chk("t5_recover_addr", 64'(fa), 64'h500);

    // async reset in the middle of BUSY
    lat = 0; addr[0] = 32'h600; rreq = 2'b01;
    for (int i = 0; i < 10 && !mr0; i++) @(negedge clk);
    chk("t6_busy", 64'(mr0), 64'd1);
    #2; rst0 = 1'b0; rst1 = 1'b0;
    #1;
    chk("t6_async_drop", 64'(mr0), 64'd0);
    chk("t6_no_valid", 64'(v0), 64'd0);
    rreq = 2'b11; addr[1] = 32'h700; lat = 1; mdata = 32'h600D600D;
    repeat (2) @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1;
    expect_c(2'b01, 32'h600D600D, 1'b0);
    run_txn(rc, wc, fa, fd, fb, fw);
    chk("t6_first_grant_addr", 64'(fa), 64'h600);

    repeat (4) @(negedge clk);
    chk("queue_empty", 64'(q0.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
